// File: rtl/alu_iterative_if.sv
// Request/response bundle between the execute stage and the iterative ALU.
// The master drives the operation request; the slave returns status and result.
interface alu_iterative_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [3:0]       Operation;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero;

  modport master (
    output start, Operation, SrcA, SrcB,
    input  busy, done, ALUResult, Zero
  );

  modport slave (
    input  start, Operation, SrcA, SrcB,
    output busy, done, ALUResult, Zero
  );
endinterface

// File: rtl/alu_iterative.sv
// Execute-stage ALU: single-cycle logic/arith/compare ops, plus a 1-bit-per-cycle
// shifter for SLL/SRL/SRA that holds busy while it iterates.
module alu_iterative #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic           clk,
  input  logic           reset,
  alu_iterative_if.slave bus_io
);

  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpOr  = 4'b0001;
  localparam logic [3:0] OpAdd = 4'b0010;
  localparam logic [3:0] OpXor = 4'b0011;
  localparam logic [3:0] OpSll = 4'b0100;
  localparam logic [3:0] OpSrl = 4'b0101;
  localparam logic [3:0] OpSub = 4'b0110;
  localparam logic [3:0] OpSra = 4'b0111;
  localparam logic [3:0] OpBeq = 4'b1000;
  localparam logic [3:0] OpBne = 4'b1001;
  localparam logic [3:0] OpBge = 4'b1011;
  localparam logic [3:0] OpSlt = 4'b1100;
  localparam logic [3:0] OpJal = 4'b1101;
  localparam logic [3:0] OpBlt = 4'b1110;

  localparam logic [SHAMT_W-1:0] CntOne = {{(SHAMT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e             state_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   result_q;
  logic [WIDTH-1:0]   acc_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic [3:0]         op_q;

  logic [WIDTH-1:0]   src_a;
  logic [WIDTH-1:0]   src_b;
  logic [3:0]         op;
  logic [SHAMT_W-1:0] shamt;
  logic               is_shift;
  logic               signed_lt;
  logic [WIDTH-1:0]   single_res;
  logic [WIDTH-1:0]   shift_step;

  // Single-cycle datapath, evaluated on the live request inputs.
  always_comb begin
    src_a      = bus_io.SrcA;
    src_b      = bus_io.SrcB;
    op         = bus_io.Operation;
    shamt      = src_b[SHAMT_W-1:0];
    is_shift   = (op == OpSll) || (op == OpSrl) || (op == OpSra);
    signed_lt  = $signed(src_a) < $signed(src_b);
    single_res = '0;
    case (op)
      OpAnd:                    single_res = src_a & src_b;
      OpOr:                     single_res = src_a | src_b;
      OpAdd:                    single_res = src_a + src_b;
      OpXor:                    single_res = src_a ^ src_b;
      OpSub:                    single_res = src_a - src_b;
      // Only reached with shamt==0, which returns A unchanged.
      OpSll, OpSrl, OpSra:      single_res = src_a;
      OpSlt, OpBlt:             single_res = {{(WIDTH-1){1'b0}}, signed_lt};
      OpBge:                    single_res = {{(WIDTH-1){1'b0}}, ~signed_lt};
      OpBeq:                    single_res = {{(WIDTH-1){1'b0}}, src_a == src_b};
      OpBne:                    single_res = {{(WIDTH-1){1'b0}}, src_a != src_b};
      OpJal:                    single_res = {{(WIDTH-1){1'b0}}, 1'b1};
      default:                  single_res = '0;
    endcase
  end

  // One step of the iterative shifter, direction/fill taken from the latched op.
  always_comb begin
    shift_step = acc_q;
    case (op_q)
      OpSll:   shift_step = {acc_q[WIDTH-2:0], 1'b0};
      OpSrl:   shift_step = {1'b0, acc_q[WIDTH-1:1]};
      OpSra:   shift_step = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
      default: shift_step = acc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      op_q     <= OpAnd;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus_io.start) begin
            if (is_shift && (shamt != '0)) begin
              acc_q   <= src_a;
              cnt_q   <= shamt;
              op_q    <= op;
              busy_q  <= 1'b1;
              state_q <= StShift;
            end else begin
              result_q <= single_res;
              done_q   <= 1'b1;
            end
          end
        end
        StShift: begin
          acc_q <= shift_step;
          cnt_q <= cnt_q - CntOne;
          if (cnt_q == CntOne) begin
            result_q <= shift_step;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus_io.busy      = busy_q;
  assign bus_io.done      = done_q;
  assign bus_io.ALUResult = result_q;
  assign bus_io.Zero      = (result_q == '0);

`ifndef SYNTHESIS
  busy_done_exclusive_a: assert property (@(posedge clk) disable iff (!reset)
    !(busy_q && done_q));
`endif

endmodule

// File: tb/tb_alu_iterative.sv
// Scoreboard bench for alu_iterative: expected results are queued at issue time
// and popped when done is observed.
module tb_alu_iterative;

  logic clk;
  logic reset;

  alu_iterative_if #(.WIDTH(32)) bus ();

  alu_iterative #(
    .WIDTH   (32),
    .SHAMT_W (5)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          busy;
  } vec_t;

  logic [31:0] sb_q[$];
  int n_checks;
  int n_fail;

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [4:0]  sh;
    logic [31:0] r;
    sh = b[4:0];
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0011: r = a ^ b;
      4'b0110: r = a - b;
      4'b0100: r = a << sh;
      4'b0101: r = a >> sh;
      4'b0111: r = $unsigned($signed(a) >>> sh);
      4'b1100: r = {31'b0, $signed(a) < $signed(b)};
      4'b1110: r = {31'b0, $signed(a) < $signed(b)};
      4'b1011: r = {31'b0, $signed(a) >= $signed(b)};
      4'b1000: r = {31'b0, a == b};
      4'b1001: r = {31'b0, a != b};
      4'b1101: r = 32'd1;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Drive one request for a single cycle starting at a falling edge; queue its result.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expv);
    bus.start     = 1'b1;
    bus.Operation = op;
    bus.SrcA      = a;
    bus.SrcB      = b;
    sb_q.push_back(expv);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit got, output int busy_cnt,
                           output bit overlap);
    got      = 1'b0;
    busy_cnt = 0;
    overlap  = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.busy && bus.done) overlap = 1'b1;
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      if (bus.busy) busy_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy);
    end
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++; $display("FAIL reset_done: got %b want 0", bus.done);
    end
    n_checks++;
    if (bus.ALUResult !== 32'h0) begin
      n_fail++; $display("FAIL reset_result: got %h want 0", bus.ALUResult);
    end
    n_checks++;
    if (bus.Zero !== 1'b1) begin
      n_fail++; $display("FAIL reset_zero: got %b want 1", bus.Zero);
    end
  endtask

  task automatic test_single_cycle();
    vec_t        v[$];
    logic [3:0]  ops[7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0110, 4'b1010, 4'b1111};
    bit          got, ov;
    int          bc;
    logic [31:0] expv;
    v.push_back('{4'b0010, 32'hFFFF_FFFF, 32'h1, 32'h0, 0});
    v.push_back('{4'b0110, 32'h3, 32'h5, 32'hFFFF_FFFE, 0});
    v.push_back('{4'b1010, 32'h5, 32'h5, 32'h0, 0});
    v.push_back('{4'b1111, 32'hFFFF_FFFF, 32'h1, 32'h0, 0});
    for (int i = 0; i < 8; i++) begin
      vec_t r;
      r.op  = ops[$urandom_range(0, 6)];
      r.a   = $urandom;
      r.b   = $urandom;
      r.exp = model(r.op, r.a, r.b);
      r.busy = 0;
      v.push_back(r);
    end
    foreach (v[i]) begin
      issue(v[i].op, v[i].a, v[i].b, v[i].exp);
      wait_done(4, got, bc, ov);
      n_checks++;
      if (!got || bc != 0) begin
        n_fail++;
        $display("FAIL single_latency op=%b: done=%b busy_cycles=%0d want done in 1 with 0 busy",
                 v[i].op, got, bc);
      end
      expv = sb_q.pop_front();
      n_checks++;
      if (bus.ALUResult !== expv) begin
        n_fail++;
        $display("FAIL single_result op=%b a=%h b=%h: got %h want %h",
                 v[i].op, v[i].a, v[i].b, bus.ALUResult, expv);
      end
      n_checks++;
      if (bus.Zero !== (expv == 32'h0)) begin
        n_fail++;
        $display("FAIL single_zero op=%b: got %b want %b", v[i].op, bus.Zero, expv == 32'h0);
      end
    end
  endtask

  task automatic test_compare();
    vec_t        v[$];
    bit          got, ov;
    int          bc;
    logic [31:0] expv;
    v.push_back('{4'b1100, 32'h8000_0000, 32'h1, 32'h1, 0});
    v.push_back('{4'b1100, 32'h1, 32'h8000_0000, 32'h0, 0});
    v.push_back('{4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 0});
    v.push_back('{4'b1011, 32'h8000_0000, 32'h0, 32'h0, 0});
    v.push_back('{4'b1110, 32'h5, 32'hFFFF_FFFD, 32'h0, 0});
    v.push_back('{4'b1110, 32'hFFFF_FFFD, 32'h5, 32'h1, 0});
    v.push_back('{4'b1000, 32'h7, 32'h7, 32'h1, 0});
    v.push_back('{4'b1001, 32'h7, 32'h7, 32'h0, 0});
    v.push_back('{4'b1001, 32'h7, 32'h8, 32'h1, 0});
    v.push_back('{4'b1101, 32'h0, 32'h0, 32'h1, 0});
    foreach (v[i]) begin
      issue(v[i].op, v[i].a, v[i].b, v[i].exp);
      wait_done(4, got, bc, ov);
      n_checks++;
      if (!got) begin
        n_fail++; $display("FAIL cmp_done op=%b: got no done want done", v[i].op);
      end
      expv = sb_q.pop_front();
      n_checks++;
      if (bus.ALUResult !== expv) begin
        n_fail++;
        $display("FAIL cmp_result op=%b a=%h b=%h: got %h want %h",
                 v[i].op, v[i].a, v[i].b, bus.ALUResult, expv);
      end
    end
  endtask

  task automatic test_shifts();
    vec_t        v[$];
    logic [3:0]  sops[3] = '{4'b0100, 4'b0101, 4'b0111};
    bit          got, ov;
    int          bc;
    logic [31:0] expv;
    v.push_back('{4'b0111, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 31});
    v.push_back('{4'b0101, 32'h8000_0000, 32'd31, 32'h1, 31});
    v.push_back('{4'b0100, 32'h1, 32'h25, 32'h20, 5});
    v.push_back('{4'b0100, 32'h1234, 32'h20, 32'h1234, 0});
    for (int i = 0; i < 6; i++) begin
      vec_t r;
      r.op   = sops[$urandom_range(0, 2)];
      r.a    = $urandom;
      r.b    = {$urandom_range(0, 7), 5'($urandom_range(1, 9))};
      r.exp  = model(r.op, r.a, r.b);
      r.busy = int'(r.b[4:0]);
      v.push_back(r);
    end
    foreach (v[i]) begin
      issue(v[i].op, v[i].a, v[i].b, v[i].exp);
      wait_done(64, got, bc, ov);
      n_checks++;
      if (!got || bc != v[i].busy) begin
        n_fail++;
        $display("FAIL shift_busy op=%b b=%h: done=%b busy_cycles=%0d want %0d",
                 v[i].op, v[i].b, got, bc, v[i].busy);
      end
      n_checks++;
      if (ov || bus.busy !== 1'b0) begin
        n_fail++; $display("FAIL shift_overlap op=%b: busy with done got 1 want 0", v[i].op);
      end
      expv = sb_q.pop_front();
      n_checks++;
      if (bus.ALUResult !== expv) begin
        n_fail++;
        $display("FAIL shift_result op=%b a=%h b=%h: got %h want %h",
                 v[i].op, v[i].a, v[i].b, bus.ALUResult, expv);
      end
    end
  endtask

  task automatic test_start_during_shift();
    bit          got, ov;
    int          bc;
    logic [31:0] expv;
    issue(4'b0101, 32'h0000_00F0, 32'd4, 32'h0000_000F);
    bus.start     = 1'b1;
    bus.Operation = 4'b0010;
    bus.SrcA      = 32'hDEAD_0000;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(16, got, bc, ov);
    n_checks++;
    if (!got || bc != 3) begin
      n_fail++;
      $display("FAIL ignore_start_busy: done=%b busy_remaining=%0d want 3", got, bc);
    end
    expv = sb_q.pop_front();
    n_checks++;
    if (bus.ALUResult !== expv) begin
      n_fail++; $display("FAIL ignore_start_result: got %h want %h", bus.ALUResult, expv);
    end
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_start_not_queued: done=%b busy=%b want 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_held_start();
    logic [31:0] expv;
    bus.start     = 1'b1;
    bus.Operation = 4'b0100;
    bus.SrcA      = 32'h3;
    bus.SrcB      = 32'h2;
    sb_q.push_back(32'hC);
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL held_busy1: got %b want 1", bus.busy);
    end
    bus.Operation = 4'b0010;
    bus.SrcA      = 32'd10;
    bus.SrcB      = 32'd20;
    sb_q.push_back(32'd30);
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL held_busy2: busy=%b done=%b want 1 0", bus.busy, bus.done);
    end
    @(negedge clk);
    expv = sb_q.pop_front();
    n_checks++;
    if (bus.done !== 1'b1 || bus.ALUResult !== expv) begin
      n_fail++;
      $display("FAIL held_shift_done: done=%b result=%h want 1 %h", bus.done, bus.ALUResult, expv);
    end
    @(negedge clk);
    bus.start = 1'b0;
    expv = sb_q.pop_front();
    n_checks++;
    if (bus.done !== 1'b1 || bus.ALUResult !== expv) begin
      n_fail++;
      $display("FAIL held_next_done: done=%b result=%h want 1 %h", bus.done, bus.ALUResult, expv);
    end
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL held_idle: done=%b busy=%b want 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] as[3] = '{32'd1, 32'd100, 32'hFFFF_FFFF};
    logic [31:0] bs[3] = '{32'd2, 32'd200, 32'd2};
    logic [31:0] es[3] = '{32'd3, 32'd300, 32'd1};
    logic [31:0] expv;
    for (int i = 0; i <= 3; i++) begin
      if (i > 0) begin
        expv = sb_q.pop_front();
        n_checks++;
        if (bus.done !== 1'b1 || bus.ALUResult !== expv) begin
          n_fail++;
          $display("FAIL b2b_%0d: done=%b result=%h want 1 %h", i, bus.done, bus.ALUResult, expv);
        end
      end
      if (i < 3) begin
        bus.start     = 1'b1;
        bus.Operation = 4'b0010;
        bus.SrcA      = as[i];
        bus.SrcB      = bs[i];
        sb_q.push_back(es[i]);
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_end_done: got %b want 0", bus.done);
    end
  endtask

  task automatic test_reset_abort();
    bit saw_done;
    bus.start     = 1'b1;
    bus.Operation = 4'b0100;
    bus.SrcA      = 32'h1;
    bus.SrcB      = 32'd20;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL abort_pre_busy: got %b want 1", bus.busy);
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL abort_state: busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
    n_checks++;
    if (bus.ALUResult !== 32'h0 || bus.Zero !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_result: result=%h zero=%b want 0 1", bus.ALUResult, bus.Zero);
    end
    saw_done = 1'b0;
    repeat (24) begin
      @(negedge clk);
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done) begin
      n_fail++; $display("FAIL abort_no_completion: activity seen 1 want 0");
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.Operation = 4'b0000;
    bus.SrcA      = 32'h0;
    bus.SrcB      = 32'h0;
    test_reset();
    test_single_cycle();
    test_compare();
    test_shifts();
    test_start_during_shift();
    test_held_start();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
